pit_lookup_engine: RTL
======================

Name: pit_lookup_engine

Overview:
- Parametrised successor of the PIT hash table for the NDN router datapath.
- Hashes a length-masked name prefix into a direct-mapped table of DEPTH entries.
- Full-tag compare distinguishes true hits from collisions.
- Supports LOOKUP, INSERT (allocates a BLOCK_SIZE-aligned content-store address) and REMOVE, over a valid/ready request port and a fixed-latency response pulse.

Parameters:
- PREFIX_W, 64: prefix width in bits; must be a multiple of 8.
- LEN_W, 5: width of the prefix-length field, which is in bytes.
- IDX_W, 10: hash index width; localparam DEPTH = 2**IDX_W.
- ADDR_W, 62: width of the allocated content-store address.
- BLOCK_SIZE, 1024: address increment per allocation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request this cycle.
- req_op  in  2  request operation: 00 LOOKUP, 01 INSERT, 10 REMOVE, 11 reserved.
- req_prefix  in  PREFIX_W  name prefix.
- req_len  in  LEN_W  significant prefix bytes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  response status: 00 MISS, 01 HIT, 10 INSERTED, 11 COLLISION.
- rsp_addr  out  ADDR_W  entry address on HIT or INSERTED; 0 otherwise.
- rsp_index  out  IDX_W  hash index used.
- occupancy  out  IDX_W+1  count of valid entries.

Behaviour:
- Entry format: {valid, tag[PREFIX_W], addr[ADDR_W]}.
- Length masking: effective length L = min(req_len, PREFIX_W/8). Prefix bits at position 8*L and above are zeroed before hashing and before tag storage/compare.
- Hash: XOR of consecutive IDX_W-bit chunks of the masked prefix, with the top chunk zero-extended, then XOR with L zero-extended.
- Reset values: req_ready=0, rsp_valid=0, rsp_status=0, rsp_addr=0, rsp_index=0, occupancy=0, next_addr=0, FSM in CLEAR with clear_ptr=0.
- CLEAR state:
  - Writes valid=0 to entry clear_ptr each cycle.
  - Takes DEPTH cycles, then goes to IDLE.
  - req_ready=0 throughout.
- IDLE state:
  - req_ready=1.
  - On req_valid, latch op, masked prefix and L, then go to HASH.
- HASH state: the registered hash is produced by the sub-module; go to CMP.
- CMP state: read entry[hash]; hit = valid && tag==masked prefix. Decide the action, perform at most one table write, register the response fields, then go to RESP.
  - LOOKUP: hit gives HIT with the stored addr; otherwise MISS.
  - INSERT on hit: HIT with the stored addr; no write.
  - INSERT on an empty slot:
    - Write the entry with addr=next_addr.
    - Respond INSERTED with addr=next_addr.
    - next_addr += BLOCK_SIZE, modulo 2**ADDR_W (silent wrap).
    - occupancy++.
  - INSERT on a valid slot with a different tag: COLLISION; no write; next_addr unchanged.
  - REMOVE on hit: clear valid; respond HIT with the old addr; occupancy--.
  - REMOVE on miss: MISS.
  - Reserved op: MISS; no state change.
- RESP state: rsp_valid=1 for exactly one cycle; go to IDLE.
- Response outputs hold their value until the next response; rsp_valid is the only pulse.
- Latency and throughput:
  - Request accepted at cycle T; rsp_valid at cycle T+3.
  - One request per 4 cycles.
  - No response backpressure.
- rst in any state:
  - Aborts any in-flight request; no response is issued.
  - Restarts CLEAR from index 0 and restores all reset values.
- occupancy never exceeds DEPTH, because each index holds one entry.

Decomposition:
- Shared package pit_pkg holds:
  - op encodings (OP_LOOKUP, OP_INSERT, OP_REMOVE);
  - status encodings (ST_MISS, ST_HIT, ST_INSERTED, ST_COLLISION);
  - FSM state constants (CLEAR, IDLE, HASH, CMP, RESP).
- Sub-module pit_hash_fold:
  - Registered XOR-fold of the masked prefix and L into IDX_W bits, one-cycle latency.
  - Parametrised by PREFIX_W, LEN_W and IDX_W.

Test Plan:
- Reset then idle: req_ready stays 0 for exactly 1024 cycles after rst falls, then rises to 1; occupancy=0.
- INSERT prefix 0x1, len 8 -> rsp_valid at T+3, INSERTED, index 9, addr 0, occupancy 1. Repeat the same INSERT -> HIT, addr 0. Then INSERT prefix 0x2, len 8 -> INSERTED, index 10, addr 1024.
- With 0x1 installed, INSERT prefix 0x400, len 8 (index 9) -> COLLISION; occupancy unchanged; next INSERT still receives addr 2048.
- Masking: INSERT prefix 0xFF01, len 1 -> index 0; LOOKUP prefix 0xAA01, len 1 -> HIT with the same addr; LOOKUP prefix 0xFF01, len 2 -> MISS.
- REMOVE prefix 0x1, len 8 -> HIT, addr 0, occupancy decrements; following LOOKUP -> MISS.
- Address wrap with ADDR_W=11 and BLOCK_SIZE=1024: third distinct INSERT returns addr 0.
- Reset mid-operation: assert rst in CMP during an INSERT -> no rsp_valid, table cleared, occupancy 0.

Source files
------------

// File: rtl/pit_pkg.sv
// Shared encodings for the PIT lookup engine: request ops, response status and FSM states.
package pit_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_REMOVE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_MISS      = 2'b00,
    ST_HIT       = 2'b01,
    ST_INSERTED  = 2'b10,
    ST_COLLISION = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    HASH,
    CMP,
    RESP
  } state_e;

endpackage

// File: rtl/pit_hash_fold.sv
// Registered XOR-fold of a masked prefix and its byte length into an IDX_W-bit table index.
module pit_hash_fold #(
  parameter int unsigned PREFIX_W = 64,
  parameter int unsigned LEN_W    = 5,
  parameter int unsigned IDX_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PREFIX_W-1:0] prefix,
  input  logic [LEN_W-1:0]    len,
  output logic [IDX_W-1:0]    hash
);

  localparam int unsigned NCHUNK = (PREFIX_W + IDX_W - 1) / IDX_W;

  logic [NCHUNK*IDX_W-1:0] padded;
  logic [IDX_W-1:0]        fold;

  // The top chunk is zero-extended by padding the prefix up to a whole number of chunks.
  always_comb begin
    padded                 = '0;
    padded[PREFIX_W-1:0]   = prefix;
    fold                   = IDX_W'(len);
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      fold = fold ^ padded[i*IDX_W +: IDX_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hash <= '0;
    else     hash <= fold;
  end

endmodule

// File: rtl/pit_lookup_engine.sv
// Direct-mapped PIT: hashed, length-masked name prefixes with LOOKUP/INSERT/REMOVE and
// a fixed three-cycle response pulse; the table is swept invalid after every reset.
module pit_lookup_engine
  import pit_pkg::*;
#(
  parameter int unsigned PREFIX_W   = 64,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned ADDR_W     = 62,
  parameter int unsigned BLOCK_SIZE = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [PREFIX_W-1:0] req_prefix,
  input  logic [LEN_W-1:0]    req_len,
  output logic                rsp_valid,
  output logic [1:0]          rsp_status,
  output logic [ADDR_W-1:0]   rsp_addr,
  output logic [IDX_W-1:0]    rsp_index,
  output logic [IDX_W:0]      occupancy
);

  localparam int unsigned DEPTH     = 2**IDX_W;
  localparam int unsigned MAX_BYTES = PREFIX_W / 8;

  typedef struct packed {
    logic                valid;
    logic [PREFIX_W-1:0] tag;
    logic [ADDR_W-1:0]   addr;
  } entry_t;

  entry_t tbl [DEPTH];

  state_e              state;
  op_e                 op_q;
  logic [PREFIX_W-1:0] prefix_q;
  logic [LEN_W-1:0]    len_q;
  logic [IDX_W-1:0]    clear_ptr;
  logic [IDX_W-1:0]    hash;
  logic [ADDR_W-1:0]   next_addr;

  logic [LEN_W-1:0]    eff_len;
  logic [PREFIX_W-1:0] masked;
  entry_t              cur;
  logic                hit;

  always_comb begin
    eff_len = req_len;
    if (32'(req_len) > MAX_BYTES) eff_len = LEN_W'(MAX_BYTES);
    masked = '0;
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      if (b < 32'(eff_len)) masked[8*b +: 8] = req_prefix[8*b +: 8];
    end
  end

  // Hash samples the latched request; its output is valid from the CMP state onward.
  pit_hash_fold #(
    .PREFIX_W(PREFIX_W),
    .LEN_W   (LEN_W),
    .IDX_W   (IDX_W)
  ) u_hash (
    .clk   (clk),
    .rst   (rst),
    .prefix(prefix_q),
    .len   (len_q),
    .hash  (hash)
  );

  assign cur = tbl[hash];
  assign hit = cur.valid && (cur.tag == prefix_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clear_ptr  <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_addr   <= '0;
      rsp_index  <= '0;
      occupancy  <= '0;
      next_addr  <= '0;
      op_q       <= OP_LOOKUP;
      prefix_q   <= '0;
      len_q      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        CLEAR: begin
          tbl[clear_ptr].valid <= 1'b0;
          clear_ptr            <= clear_ptr + 1'b1;
          if (clear_ptr == IDX_W'(DEPTH - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            prefix_q  <= masked;
            len_q     <= eff_len;
            req_ready <= 1'b0;
            state     <= HASH;
          end
        end
        HASH: state <= CMP;
        CMP: begin
          rsp_valid  <= 1'b1;
          rsp_index  <= hash;
          rsp_status <= ST_MISS;
          rsp_addr   <= '0;
          state      <= RESP;
          case (op_q)
            OP_LOOKUP: begin
              if (hit) begin
                rsp_status <= ST_HIT;
                rsp_addr   <= cur.addr;
              end
            end
            OP_INSERT: begin
              if (hit) begin
                rsp_status <= ST_HIT;
                rsp_addr   <= cur.addr;
              end else if (!cur.valid) begin
                tbl[hash]  <= '{valid: 1'b1, tag: prefix_q, addr: next_addr};
                rsp_status <= ST_INSERTED;
                rsp_addr   <= next_addr;
                next_addr  <= next_addr + ADDR_W'(BLOCK_SIZE);
                occupancy  <= occupancy + 1'b1;
              end else begin
                rsp_status <= ST_COLLISION;
              end
            end
            OP_REMOVE: begin
              if (hit) begin
                tbl[hash].valid <= 1'b0;
                rsp_status      <= ST_HIT;
                rsp_addr        <= cur.addr;
                occupancy       <= occupancy - 1'b1;
              end
            end
            default: ;
          endcase
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= CLEAR;
          clear_ptr <= '0;
        end
      endcase
    end
  end

endmodule
